otp_stream_cryptor: RTL

//  Streaming one-time-pad cipher engine: XORs each message beat with one key beat from an internal key buffer.

---
 rtl/otp_stream_cryptor_pkg.sv | 13 +
 rtl/otp_stream_cryptor_if.sv | 32 +++
 rtl/otp_key_fifo.sv | 50 +++++
 rtl/otp_stream_cryptor.sv | 116 +++++++++++
 4 files changed

// File: rtl/otp_stream_cryptor_pkg.sv
// Shared constants and types for the one-time-pad stream cryptor.
package otp_stream_cryptor_pkg;

  // Default beat width for message, key and output words.
  localparam int unsigned KeySize = 8;

  // WIPE sweeps the key buffer to zero; STREAM is normal operation.
  typedef enum logic [0:0] {
    StWipe   = 1'b0,
    StStream = 1'b1
  } otp_state_e;

endpackage

// File: rtl/otp_stream_cryptor_if.sv
// Key, message and output streams of the cryptor, each a valid/ready handshake.
interface otp_stream_cryptor_if
  import otp_stream_cryptor_pkg::*;
#(
  parameter int unsigned DATA_W = KeySize
);
  logic              key_valid;
  logic              key_ready;
  logic [DATA_W-1:0] key_data;

  logic              msg_valid;
  logic              msg_ready;
  logic [DATA_W-1:0] msg_data;
  logic              msg_last;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  // Source/sink side.
  modport master (
    output key_valid, key_data, msg_valid, msg_data, msg_last, out_ready,
    input  key_ready, msg_ready, out_valid, out_data, out_last
  );

  // Cryptor side.
  modport slave (
    input  key_valid, key_data, msg_valid, msg_data, msg_last, out_ready,
    output key_ready, msg_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/otp_key_fifo.sv
// Key word storage: circular buffer whose entries are zeroed on consumption,
// plus an external sweep port used to wipe one entry per cycle.
module otp_key_fifo #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned KEY_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         rd_en,
  output logic [DATA_W-1:0]            rd_data,
  input  logic                         wipe_en,
  input  logic [$clog2(KEY_DEPTH)-1:0] wipe_idx,
  output logic [$clog2(KEY_DEPTH):0]   level
);
  localparam int unsigned PtrW = $clog2(KEY_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [DATA_W-1:0] mem_q [KEY_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q;

  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Storage: write new key, zero the consumed entry, zero the swept entry.
  // Write and consume never alias: equal pointers mean empty (no read) or full (no write).
  always_ff @(posedge clk) begin
    if (wipe_en) mem_q[wipe_idx] <= '0;
    if (wr_en)   mem_q[wr_ptr_q] <= wr_data;
    if (rd_en)   mem_q[rd_ptr_q] <= '0;
  end

  // Pointers and fill level; power-of-two depth makes the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en && !rd_en)      level_q <= level_q + 1'b1;
      else if (!wr_en && rd_en) level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: rtl/otp_stream_cryptor.sv
// One-time-pad stream cipher: each message beat is XORed with a fresh key word,
// which is wiped as it is used. Zeroize sweeps the whole key buffer.
module otp_stream_cryptor
  import otp_stream_cryptor_pkg::*;
#(
  parameter int unsigned DATA_W    = KeySize,
  parameter int unsigned KEY_DEPTH = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       zeroize,
  output logic                       busy,
  otp_stream_cryptor_if.slave        bus,
  output logic [$clog2(KEY_DEPTH):0] key_level,
  output logic [CNT_W-1:0]           frame_count
);
  localparam int unsigned PtrW = $clog2(KEY_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  otp_state_e        state_q, state_d;
  logic [PtrW-1:0]   wipe_idx_q, wipe_idx_d;
  logic              stream;
  logic              key_wr, msg_acc, out_take;
  logic [DATA_W-1:0] key_word;
  logic              out_valid_q, out_last_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CNT_W-1:0]  frame_count_q;

  assign stream = (state_q == StStream);
  assign busy   = !stream;

  assign bus.key_ready = stream && !zeroize && (key_level != LvlW'(KEY_DEPTH));
  assign bus.msg_ready = stream && !zeroize && (key_level != '0) &&
                         (!out_valid_q || bus.out_ready);

  assign key_wr   = bus.key_valid && bus.key_ready;
  assign msg_acc  = bus.msg_valid && bus.msg_ready;
  assign out_take = out_valid_q && bus.out_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign frame_count   = frame_count_q;

  otp_key_fifo #(
    .DATA_W    (DATA_W),
    .KEY_DEPTH (KEY_DEPTH)
  ) u_key_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (stream && zeroize),
    .wr_en    (key_wr),
    .wr_data  (bus.key_data),
    .rd_en    (msg_acc),
    .rd_data  (key_word),
    .wipe_en  (busy),
    .wipe_idx (wipe_idx_q),
    .level    (key_level)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StWipe;
      wipe_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      wipe_idx_q <= wipe_idx_d;
    end
  end

  // Next state: sweep one entry per cycle; zeroize only restarts from STREAM.
  always_comb begin
    state_d    = state_q;
    wipe_idx_d = wipe_idx_q;
    unique case (state_q)
      StWipe: begin
        wipe_idx_d = wipe_idx_q + 1'b1;
        if (wipe_idx_q == PtrW'(KEY_DEPTH - 1)) state_d = StStream;
      end
      StStream: begin
        if (zeroize) begin
          state_d    = StWipe;
          wipe_idx_d = '0;
        end
      end
      default: state_d = StWipe;
    endcase
  end

  // Output register; survives zeroize so a pending beat still drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (msg_acc) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.msg_data ^ key_word;
      out_last_q  <= bus.msg_last;
    end else if (out_take) begin
      out_valid_q <= 1'b0;
    end
  end

  // Count frames whose last beat has been delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count_q <= '0;
    end else if (out_take && out_last_q) begin
      frame_count_q <= frame_count_q + 1'b1;
    end
  end

endmodule
